// File: rtl/parking_meter_ctrl_if.sv
// Coin/preset inputs and remaining-time/status outputs of the parking meter controller.
interface parking_meter_ctrl_if #(
  parameter int unsigned W = 14
);
  logic [3:0]   btn;
  logic [1:0]   sw;
  logic [W-1:0] count;
  logic         expired;
  logic         low;
  logic         disp_en;
  logic         tick;

  modport master (output btn, sw, input count, expired, low, disp_en, tick);
  modport slave  (input btn, sw, output count, expired, low, disp_en, tick);
endinterface

// File: rtl/parking_meter_ctrl.sv
// Parking meter: remaining seconds with coin adds, preset loads, prescaled countdown
// and blink control for the downstream 7-segment driver.
module parking_meter_ctrl #(
  parameter int unsigned W          = 14,
  parameter int unsigned MAX_COUNT  = 9999,
  parameter int unsigned ADD0       = 50,
  parameter int unsigned ADD1       = 150,
  parameter int unsigned ADD2       = 200,
  parameter int unsigned ADD3       = 500,
  parameter int unsigned PRESET0    = 10,
  parameter int unsigned PRESET1    = 205,
  parameter int unsigned LOW_THRESH = 200,
  parameter int unsigned TICK_DIV   = 100000000
) (
  input  logic                clk,
  input  logic                rst_n,
  parking_meter_ctrl_if.slave io_bus
);

  localparam int unsigned SW = W + 3;
  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PCNT_HALF = PW'(TICK_DIV / 2 - 1);

  logic [3:0]    r_btn_s1, r_btn_s2, r_btn_s3, r_btn_arm;
  logic [1:0]    r_sw_s1, r_sw_s2, r_sw_s3, r_sw_arm;
  logic [1:0]    r_vld;
  logic [PW-1:0] r_pcnt;
  logic [W-1:0]  r_count;
  logic          r_half_ph;
  logic          r_sec_ph;

  logic [3:0]    w_btn_rise;
  logic [1:0]    w_sw_rise;
  logic          w_tick;
  logic          w_half;
  logic [SW-1:0] w_sum;
  logic [SW-1:0] w_dec;
  logic [W-1:0]  w_clamp;
  logic [W-1:0]  w_count_d;
  logic          w_wake;
  logic          w_expired;
  logic          w_low;

  // An input must be seen low after reset before its edges count, so a button
  // held through reset release does not act until it is released and pressed again.
  assign w_btn_rise = r_btn_s2 & ~r_btn_s3 & r_btn_arm;
  assign w_sw_rise  = r_sw_s2 & ~r_sw_s3 & r_sw_arm;

  assign w_tick = (r_pcnt == PCNT_LAST);
  assign w_half = (r_pcnt == PCNT_HALF) || w_tick;

  always_comb begin
    w_sum = {3'b000, r_count};
    if (w_btn_rise[0]) w_sum = w_sum + SW'(ADD0);
    if (w_btn_rise[1]) w_sum = w_sum + SW'(ADD1);
    if (w_btn_rise[2]) w_sum = w_sum + SW'(ADD2);
    if (w_btn_rise[3]) w_sum = w_sum + SW'(ADD3);
    w_dec = w_sum;
    if (w_tick && (w_sum != '0)) w_dec = w_sum - SW'(1);
    w_clamp = (w_dec > SW'(MAX_COUNT)) ? W'(MAX_COUNT) : w_dec[W-1:0];
    w_wake  = (|w_btn_rise) && (r_count == '0) && (w_clamp != '0);
    if (w_sw_rise[1]) begin
      w_count_d = W'(PRESET1);
    end else if (w_sw_rise[0]) begin
      w_count_d = W'(PRESET0);
    end else begin
      w_count_d = w_clamp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_s1  <= '0;
      r_btn_s2  <= '0;
      r_btn_s3  <= '0;
      r_btn_arm <= '0;
      r_sw_s1   <= '0;
      r_sw_s2   <= '0;
      r_sw_s3   <= '0;
      r_sw_arm  <= '0;
      r_vld     <= '0;
      r_pcnt    <= '0;
      r_count   <= '0;
      r_half_ph <= 1'b1;
      r_sec_ph  <= 1'b1;
    end else begin
      r_btn_s1 <= io_bus.btn;
      r_btn_s2 <= r_btn_s1;
      r_btn_s3 <= r_btn_s2;
      r_sw_s1  <= io_bus.sw;
      r_sw_s2  <= r_sw_s1;
      r_sw_s3  <= r_sw_s2;
      // r_vld[1] marks that the second sync stage holds a real post-reset sample.
      r_vld    <= {r_vld[0], 1'b1};
      if (r_vld[1]) begin
        r_btn_arm <= r_btn_arm | ~r_btn_s2;
        r_sw_arm  <= r_sw_arm | ~r_sw_s2;
      end
      r_count <= w_count_d;
      r_pcnt  <= ((|w_sw_rise) || w_tick) ? '0 : r_pcnt + PW'(1);
      if ((|w_sw_rise) || w_wake) begin
        r_half_ph <= 1'b1;
        r_sec_ph  <= 1'b1;
      end else begin
        if (w_half) r_half_ph <= ~r_half_ph;
        if (w_tick) r_sec_ph  <= ~r_sec_ph;
      end
    end
  end

  assign w_expired = (r_count == '0);
  assign w_low     = !w_expired && (r_count < W'(LOW_THRESH));

  assign io_bus.count   = r_count;
  assign io_bus.tick    = w_tick;
  assign io_bus.expired = w_expired;
  assign io_bus.low     = w_low;
  assign io_bus.disp_en = w_expired ? r_half_ph : (w_low ? r_sec_ph : 1'b1);

endmodule
